// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, branch-redirect
// flushes, EX operand forwarding selects, and the I-cache refill sequencer.
// Saturating performance counters track stalled and redirected cycles.
// Refill FSM state is visible on dbg_state (0 RUN, 1 MISS, 2 MISS_KILL).
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1e,
  input  logic [REG_ADDR_WIDTH-1:0] rs2e,
  input  logic [REG_ADDR_WIDTH-1:0] rde,
  input  logic [REG_ADDR_WIDTH-1:0] rdm,
  input  logic [REG_ADDR_WIDTH-1:0] rdw,
  input  logic                      resultsrce0,
  input  logic                      regwritem,
  input  logic                      regwritew,
  input  logic                      pcsrce,
  input  logic                      ic_miss,
  input  logic                      ic_fill_done,
  output logic                      stallf,
  output logic                      stalld,
  output logic                      flushd,
  output logic                      flushe,
  output logic [1:0]                forwardae,
  output logic [1:0]                forwardbe,
  output logic                      ic_refill_req,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      redirect_cnt,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_MISS      = 2'd1,
    S_MISS_KILL = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_lwstall;
  logic [1:0]            w_fwd_a;
  logic [1:0]            w_fwd_b;
  logic                  w_stallf;
  logic                  w_stalld;
  logic                  w_flushd;
  logic                  w_flushe;
  logic                  w_refill_req;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_redirect_cnt;

  // Forwarding selects and load-use detection; MEM result beats WB, x0 never forwards.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (regwritem && (rdm != '0) && (rdm == rs1e))      w_fwd_a = 2'b10;
    else if (regwritew && (rdw != '0) && (rdw == rs1e)) w_fwd_a = 2'b01;
    if (regwritem && (rdm != '0) && (rdm == rs2e))      w_fwd_b = 2'b10;
    else if (regwritew && (rdw != '0) && (rdw == rs2e)) w_fwd_b = 2'b01;
    w_lwstall = resultsrce0 && (rde != '0) && ((rde == rs1d) || (rde == rs2d));
  end

  // Next-state and pipeline control; reset overrides everything with a flushed pipe.
  always_comb begin
    w_state_nxt  = r_state;
    w_stallf     = 1'b0;
    w_stalld     = 1'b0;
    w_flushd     = 1'b0;
    w_flushe     = 1'b0;
    w_refill_req = 1'b0;
    case (r_state)
      S_MISS, S_MISS_KILL: begin
        // Fetch is waiting on the refill: hold PC and feed bubbles into decode.
        w_refill_req = 1'b1;
        if (pcsrce) begin
          // PC must take the branch target even while the line is in flight.
          w_flushd = 1'b1;
          w_flushe = 1'b1;
        end else begin
          w_stallf = 1'b1;
          if (w_lwstall) begin
            w_stalld = 1'b1;
            w_flushe = 1'b1;
          end else begin
            w_flushd = 1'b1;
          end
        end
        if (ic_fill_done)  w_state_nxt = S_RUN;
        else if (pcsrce)   w_state_nxt = S_MISS_KILL;
      end
      default: begin
        if (pcsrce) begin
          w_flushd = 1'b1;
          w_flushe = 1'b1;
        end else if (w_lwstall) begin
          w_stallf = 1'b1;
          w_stalld = 1'b1;
          w_flushe = 1'b1;
        end else if (ic_miss) begin
          w_stallf    = 1'b1;
          w_flushd    = 1'b1;
          w_state_nxt = S_MISS;
        end
        if (r_state != S_RUN) w_state_nxt = S_RUN;
      end
    endcase
    if (rst) begin
      w_stallf     = 1'b0;
      w_stalld     = 1'b0;
      w_flushd     = 1'b1;
      w_flushe     = 1'b1;
      w_refill_req = 1'b0;
    end
  end

  // Refill FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (w_stallf && (r_stall_cnt != '1))    r_stall_cnt    <= r_stall_cnt + CNT_ONE;
      if (pcsrce && (r_redirect_cnt != '1))   r_redirect_cnt <= r_redirect_cnt + CNT_ONE;
    end
  end

  assign stallf        = w_stallf;
  assign stalld        = w_stalld;
  assign flushd        = w_flushd;
  assign flushe        = w_flushe;
  assign forwardae     = rst ? 2'b00 : w_fwd_a;
  assign forwardbe     = rst ? 2'b00 : w_fwd_b;
  assign ic_refill_req = w_refill_req;
  assign stall_cnt     = r_stall_cnt;
  assign redirect_cnt  = r_redirect_cnt;
  assign dbg_state     = r_state;

endmodule
